// File: rtl/adder_pkg.sv
// Shared width constant and operand type for the small adder family.
package adder_pkg;
  localparam int ADDER_WIDTH = 3;
  typedef logic [ADDER_WIDTH-1:0] operand_t;
endpackage

// File: rtl/three_bit_adder_full_adder.sv
// Single-bit full-adder cell used as a link in the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/three_bit_adder.sv
// Registered ripple-carry adder; result appears one clock after sampling.
// Optional registered signed-overflow output Ovf under macro ADDER_OVF_EN.
module three_bit_adder
  import adder_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  operand_t X,
  input  operand_t Y,
  output operand_t S,
`ifdef ADDER_OVF_EN
  output logic     Cout,
  output logic     Ovf
`else
  output logic     Cout
`endif
);
  localparam int WIDTH = ADDER_WIDTH;

  operand_t       sum;
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (X[i]),
      .b   (Y[i]),
      .cin (c[i]),
      .s   (sum[i]),
      .cout(c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum;
      Cout <= c[WIDTH];
    end
  end

`ifdef ADDER_OVF_EN
  // Two's-complement overflow: carry into and out of the sign bit differ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Ovf <= 1'b0;
    else        Ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_three_bit_adder.sv
// Directed self-checking bench for the registered 3-bit adder.
module tb_three_bit_adder;
  logic       clk;
  logic       rst_n;
  logic [2:0] X;
  logic [2:0] Y;
  logic [2:0] S;
  logic       Cout;
`ifdef ADDER_OVF_EN
  logic       Ovf;
`endif

  int total  = 0;
  int passed = 0;

  three_bit_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .X    (X),
    .Y    (Y),
    .S    (S),
`ifdef ADDER_OVF_EN
    .Cout (Cout),
    .Ovf  (Ovf)
`else
    .Cout (Cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [3:0] obs,
                       input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic apply(input int x, input int y);
    @(negedge clk);
    X = 3'(x);
    Y = 3'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    X = 3'd7;
    Y = 3'd7;
    #1 rst_n = 1'b0;
    #1 check("reset_assert", {Cout, S}, 4'd0);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", {Cout, S}, 4'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release_7p7", {Cout, S}, 4'd14);

    apply(0, 0);
    check("zero", {Cout, S}, 4'd0);
    apply(5, 0);
    check("identity_5p0", {Cout, S}, 4'd5);
    apply(3, 1);
    check("ripple_3p1", {Cout, S}, 4'd4);
    apply(1, 7);
    check("ripple_1p7", {Cout, S}, 4'd8);

    // Operands changing between edges must not disturb the held result
    @(negedge clk);
    X = 3'd2;
    Y = 3'd2;
    #2 check("hold_between_edges", {Cout, S}, 4'd8);
    @(posedge clk);
    #1 check("after_edge_2p2", {Cout, S}, 4'd4);

    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        apply(x, y);
        check($sformatf("sweep_%0d_%0d", x, y), {Cout, S}, 4'(x + y));
      end
    end

    apply(6, 3);
    check("pre_reset_6p3", {Cout, S}, 4'd9);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid", {Cout, S}, 4'd0);
    @(posedge clk);
    #1 check("async_reset_held", {Cout, S}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset_6p3", {Cout, S}, 4'd9);

`ifdef ADDER_OVF_EN
    apply(3, 1);
    check("ovf_3p1", {3'd0, Ovf}, 4'd1);
    apply(7, 7);
    check("ovf_7p7", {3'd0, Ovf}, 4'd0);
    apply(4, 4);
    check("ovf_4p4", {3'd0, Ovf}, 4'd1);
    check("sum_4p4", {Cout, S}, 4'd8);
    #2 rst_n = 1'b0;
    #1 check("ovf_reset", {3'd0, Ovf}, 4'd0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
